roi_binary_grid: RTL and testbench



---
 rtl/roi_binary_grid.sv | 152 +++++++++++++++
 tb/tb_roi_binary_grid.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/roi_binary_grid.sv
// Crops a square ROI out of an RGB565 stream, thresholds it to one bit per pixel and
// majority-votes each CELLxCELL block into a GRIDxGRID ping-pong bitmap read by (x,y).
module roi_binary_grid #(
  parameter int ROI_X0 = 116,
  parameter int ROI_Y0 = 100,
  parameter int CELL   = 10,
  parameter int GRID   = 28,
  parameter int THRESH = 128,
  parameter int MAJ    = 50
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        frame_start,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic [15:0] pixel_in,
  input  logic        pixel_valid,
  input  logic        invert,
  input  logic [4:0]  rd_x,
  input  logic [4:0]  rd_y,
  output logic        rd_data,
  output logic        frame_done,
  output logic        busy
);

  localparam int EDGE = GRID * CELL;
  localparam int NB   = GRID * GRID;
  localparam int IW   = $clog2(NB);

  function automatic logic [7:0] to_gray(input logic [15:0] px);
    logic [7:0]  r8, g8, b8;
    logic [15:0] acc;
    r8  = {px[15:11], px[15:13]};
    g8  = {px[10:5], px[10:9]};
    b8  = {px[4:0], px[4:2]};
    acc = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    return acc[15:8];
  endfunction

  logic        in_roi;
  logic        vld_p1, roi_p1, first_p1, last_p1;
  logic [7:0]  gray_p1;

  logic [6:0]  cnt [GRID];
  logic [3:0]  sub_x, sub_y;
  logic [4:0]  col, row;
  logic        front_sel;
  logic [NB-1:0] bm0, bm1;

  logic [3:0]  cur_sx;
  logic [4:0]  cur_col;
  logic        ink, accept, close, complete, cell_bit;
  logic [6:0]  cnt_new;
  logic [IW-1:0] widx, ridx;

  assign in_roi = (pixel_x >= 11'(ROI_X0)) && (pixel_x < 11'(ROI_X0 + EDGE)) &&
                  (pixel_y >= 11'(ROI_Y0)) && (pixel_y < 11'(ROI_Y0 + EDGE));

  // stage 1: grayscale and position flags
  always_ff @(posedge pixel_clk) begin
    if (sys_rst || frame_start) begin
      vld_p1 <= 1'b0;
      roi_p1 <= 1'b0;
    end else begin
      vld_p1 <= pixel_valid;
      roi_p1 <= in_roi;
    end
    gray_p1  <= to_gray(pixel_in);
    first_p1 <= (pixel_x == 11'(ROI_X0));
    last_p1  <= (pixel_x == 11'(ROI_X0 + EDGE - 1));
  end

  // stage 2: threshold, cell accumulation, cell close
  always_comb begin
    cur_sx   = first_p1 ? 4'd0 : sub_x;
    cur_col  = first_p1 ? 5'd0 : col;
    ink      = (gray_p1 < 8'(THRESH)) ^ invert;
    accept   = vld_p1 && roi_p1 && !frame_start &&
               (row < 5'(GRID)) && (cur_col < 5'(GRID));
    cnt_new  = accept ? cnt[cur_col] + {6'd0, ink} : 7'd0;
    close    = accept && (cur_sx == 4'(CELL - 1)) && (sub_y == 4'(CELL - 1));
    complete = close && (row == 5'(GRID - 1)) && (cur_col == 5'(GRID - 1));
    cell_bit = (cnt_new >= 7'(MAJ));
    widx     = IW'(row) * IW'(GRID) + IW'(cur_col);
    ridx     = IW'(rd_y) * IW'(GRID) + IW'(rd_x);
  end

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < GRID; i++) cnt[i] <= '0;
      sub_x      <= '0;
      sub_y      <= '0;
      col        <= '0;
      row        <= '0;
      front_sel  <= 1'b0;
      bm0        <= '0;
      bm1        <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        for (int i = 0; i < GRID; i++) cnt[i] <= '0;
        sub_x <= '0;
        sub_y <= '0;
        col   <= '0;
        row   <= '0;
        busy  <= 1'b0;
      end else if (accept) begin
        busy <= !complete;
        if (close) begin
          cnt[cur_col] <= '0;
          // the back buffer is whichever one is not currently front
          if (front_sel) bm0[widx] <= cell_bit;
          else           bm1[widx] <= cell_bit;
        end else begin
          cnt[cur_col] <= cnt_new;
        end
        if (complete) begin
          front_sel  <= ~front_sel;
          frame_done <= 1'b1;
        end
        if (cur_sx == 4'(CELL - 1)) begin
          sub_x <= '0;
          col   <= cur_col + 5'd1;
        end else begin
          sub_x <= cur_sx + 4'd1;
          col   <= cur_col;
        end
        if (last_p1) begin
          if (sub_y == 4'(CELL - 1)) begin
            sub_y <= '0;
            row   <= row + 5'd1;
          end else begin
            sub_y <= sub_y + 4'd1;
          end
        end
      end
    end
  end

  // read port: one-cycle latency from the front buffer
  always_ff @(posedge pixel_clk) begin
    if (sys_rst)
      rd_data <= 1'b0;
    else if ((rd_x < 5'(GRID)) && (rd_y < 5'(GRID)))
      rd_data <= front_sel ? bm1[ridx] : bm0[ridx];
    else
      rd_data <= 1'b0;
  end

endmodule

// File: tb/tb_roi_binary_grid.sv
// Directed bench for roi_binary_grid, built with a 4x4 grid of 10x10 cells so whole
// frames stay short; cell size, majority and threshold keep their default values.
module tb_roi_binary_grid;

  localparam int X0 = 116;
  localparam int Y0 = 100;
  localparam int C  = 10;
  localparam int G  = 4;
  localparam int E  = G * C;

  logic        clk = 1'b0;
  logic        sys_rst, frame_start, pixel_valid, invert;
  logic [10:0] pixel_x, pixel_y;
  logic [15:0] pixel_in;
  logic [4:0]  rd_x, rd_y;
  logic        rd_data, frame_done, busy;

  int ncmp = 0;
  int nfail = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic rd_swap, rd_after;

  roi_binary_grid #(.ROI_X0(X0), .ROI_Y0(Y0), .CELL(C), .GRID(G), .THRESH(128), .MAJ(50)) dut (
    .pixel_clk(clk), .sys_rst(sys_rst), .frame_start(frame_start),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .invert(invert), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // kinds: 0 black, 1 white, 2 checkerboard, 3 cell(0,0) with nb dark pixels,
  // 4 gray stripes (even cell columns just below threshold), 5 nothing written
  function automatic logic [15:0] pix_of(input int kind, input int nb, input int x, input int y);
    int cx, cy;
    cx = x / C;
    cy = y / C;
    case (kind)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return ((cx + cy) % 2 == 0) ? 16'h0000 : 16'hFFFF;
      3: begin
        if (cx == 0 && cy == 0) return (((y % C) * C + (x % C)) < nb) ? 16'h0000 : 16'hFFFF;
        if (cx == 1 && cy == 0) return 16'h0000;
        return 16'hFFFF;
      end
      default: return (cx % 2 == 0) ? 16'h7BEF : 16'h8410;
    endcase
  endfunction

  // 0x7BEF -> gray 124 (ink when invert=0); 0x8410 -> gray 130 (not ink)
  function automatic logic exp_bit(input int kind, input int nb, input logic inv, input int cx, input int cy);
    case (kind)
      0: return !inv;
      1: return inv;
      2: return ((cx + cy) % 2 == 0) ^ inv;
      3: begin
        if (cx == 0 && cy == 0) return (nb >= 50);
        return (cx == 1 && cy == 0);
      end
      4: return (cx % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic read_all(input int kind, input int nb, input logic inv, input string tag);
    for (int cy = 0; cy < G; cy++) begin
      for (int cx = 0; cx < G; cx++) begin
        rd_x = 5'(cx);
        rd_y = 5'(cy);
        @(posedge clk); #1;
        chk($sformatf("%s(%0d,%0d)", tag, cx, cy), {31'd0, rd_data}, {31'd0, exp_bit(kind, nb, inv, cx, cy)});
      end
    end
  endtask

  task automatic run_frame(input int kind, input int nb, input logic inv, input int rows_n);
    invert = inv;
    // the dark pixel presented with frame_start must be dropped
    frame_start = 1'b1;
    pixel_valid = 1'b1;
    pixel_x = 11'(X0);
    pixel_y = 11'(Y0);
    pixel_in = 16'h0000;
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("busy_after_frame_start", {31'd0, busy}, 32'd0);
    // dark pixel one row above the ROI must be ignored
    pixel_y = 11'(Y0 - 1);
    @(posedge clk); #1;
    for (int y = 0; y < rows_n; y++) begin
      for (int x = 0; x < E; x++) begin
        pixel_x = 11'(X0 + x);
        pixel_y = 11'(Y0 + y);
        pixel_in = pix_of(kind, nb, x, y);
        pixel_valid = 1'b1;
        @(posedge clk); #1;
      end
    end
    pixel_valid = 1'b0;
    if (rows_n == E) begin
      chk("done_early", {31'd0, frame_done}, 32'd0);
      chk("busy_in_frame", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("done_pulse", {31'd0, frame_done}, 32'd1);
      chk("busy_drop", {31'd0, busy}, 32'd0);
      rd_swap = rd_data;
      @(posedge clk); #1;
      chk("done_one_cycle", {31'd0, frame_done}, 32'd0);
      rd_after = rd_data;
      exp_done++;
      chk("done_count", done_cnt, exp_done);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    invert = 1'b0;
    pixel_x = '0;
    pixel_y = '0;
    pixel_in = '0;
    rd_x = '0;
    rd_y = '0;
    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b0;
    chk("rst_rd_data", {31'd0, rd_data}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    read_all(5, 0, 1'b0, "rst_bm");

    run_frame(0, 0, 1'b0, E);
    read_all(0, 0, 1'b0, "black_inv0");

    // latency: result follows the address by one edge
    rd_x = 5'd0; rd_y = 5'd0;
    @(posedge clk); #1;
    rd_x = 5'd3; rd_y = 5'd3;
    run_frame(0, 0, 1'b1, E);
    read_all(0, 0, 1'b1, "black_inv1");
    run_frame(1, 0, 1'b1, E);
    read_all(1, 0, 1'b1, "white_inv1");

    run_frame(3, 50, 1'b0, E);
    read_all(3, 50, 1'b0, "maj50");
    run_frame(3, 49, 1'b0, E);
    read_all(3, 49, 1'b0, "maj49");

    run_frame(4, 0, 1'b0, E);
    read_all(4, 0, 1'b0, "stripes");

    // abandoned half frame leaves the front untouched
    run_frame(0, 0, 1'b0, E / 2);
    repeat (3) @(posedge clk);
    #1;
    chk("half_no_done", done_cnt, exp_done);
    chk("half_busy", {31'd0, busy}, 32'd1);
    read_all(4, 0, 1'b0, "half_front");

    rd_x = 5'd1; rd_y = 5'd1;
    run_frame(2, 0, 1'b0, E);
    chk("swap_old", {31'd0, rd_swap}, {31'd0, exp_bit(4, 0, 1'b0, 1, 1)});
    chk("swap_new", {31'd0, rd_after}, {31'd0, exp_bit(2, 0, 1'b0, 1, 1)});
    read_all(2, 0, 1'b0, "checker");

    rd_x = 5'd0; rd_y = 5'd0;
    @(posedge clk); #1;
    chk("lat_a", {31'd0, rd_data}, 32'd1);
    rd_x = 5'd1;
    #2;
    chk("lat_hold", {31'd0, rd_data}, 32'd1);
    @(posedge clk); #1;
    chk("lat_b", {31'd0, rd_data}, 32'd0);
    rd_x = 5'd28; rd_y = 5'd0;
    @(posedge clk); #1;
    chk("rd_x_28", {31'd0, rd_data}, 32'd0);
    rd_x = 5'd1; rd_y = 5'd31;
    @(posedge clk); #1;
    chk("rd_y_31", {31'd0, rd_data}, 32'd0);

    // reset in the middle of a frame
    run_frame(0, 0, 1'b0, 15);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    sys_rst = 1'b1;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, frame_done}, 32'd0);
    read_all(5, 0, 1'b0, "mid_rst_bm");

    run_frame(4, 0, 1'b0, E);
    read_all(4, 0, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
